// File: rtl/svcs_hw_pkg.sv
// Shared SVCS hardware types: header image, sizing constants and parser states.
package svcs_hw_pkg;

    localparam int unsigned SVCS_MAX_SIZE  = 4096;
    localparam int unsigned SVCS_HDR_WORDS = 7;
    localparam int unsigned SVCS_HC_W      = 3;

    typedef struct packed {
        logic [63:0] trnx_type;
        logic [63:0] trnx_id;
        logic [63:0] data_type;
        logic [31:0] n_payloads;
    } cs_hdr_hw_t;

    typedef enum logic [1:0] {
        HDR,
        HDR_OUT,
        PAYLOAD,
        DISCARD
    } rx_state_t;

endpackage

// File: rtl/svcs_hs_rx_parser.sv
// Receive-side SVCS parser: splits the 32-bit word stream into a header
// handshake and a zero-latency payload burst.
module svcs_hs_rx_parser
    import svcs_hw_pkg::*;
#(
    parameter int unsigned MAX_PAYLOADS = SVCS_MAX_SIZE,
    parameter int unsigned IDX_W        = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    output logic             hdr_valid,
    input  logic             hdr_ready,
    output logic [63:0]      hdr_trnx_type,
    output logic [63:0]      hdr_trnx_id,
    output logic [63:0]      hdr_data_type,
    output logic [31:0]      hdr_n_payloads,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data,
    output logic [IDX_W-1:0] m_index,
    output logic             m_last,
    output logic             err_oversize,
    output logic [15:0]      trnx_count
);

    rx_state_t              r_state;
    rx_state_t              w_state_nxt;
    logic [SVCS_HC_W-1:0]   r_hc;
    cs_hdr_hw_t             r_hdr;
    logic [IDX_W-1:0]       r_pc;
    logic [31:0]            r_dc;
    logic                   r_err;
    logic [15:0]            r_cnt;

    logic                   w_s_acc;
    logic                   w_hdr_acc;
    logic                   w_m_acc;
    logic                   w_hc_last;
    logic                   w_oversize;
    logic                   w_pc_last;

    assign w_s_acc    = s_valid & s_ready;
    assign w_hdr_acc  = hdr_valid & hdr_ready;
    assign w_m_acc    = m_valid & m_ready;
    assign w_hc_last  = (r_hc == SVCS_HC_W'(SVCS_HDR_WORDS - 1));
    assign w_oversize = (s_data > 32'(MAX_PAYLOADS));
    assign w_pc_last  = (32'(r_pc) == (r_hdr.n_payloads - 32'd1));

    assign m_data         = s_data;
    assign m_index        = r_pc;
    assign hdr_trnx_type  = r_hdr.trnx_type;
    assign hdr_trnx_id    = r_hdr.trnx_id;
    assign hdr_data_type  = r_hdr.data_type;
    assign hdr_n_payloads = r_hdr.n_payloads;
    assign err_oversize   = r_err;
    assign trnx_count     = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake outputs are gated by rst so nothing moves before the first reset edge.
    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        hdr_valid   = 1'b0;
        m_valid     = 1'b0;
        m_last      = 1'b0;
        case (r_state)
            HDR: begin
                s_ready = !rst;
                if (s_valid && !rst && w_hc_last) begin
                    w_state_nxt = w_oversize ? DISCARD : HDR_OUT;
                end
            end
            HDR_OUT: begin
                hdr_valid = !rst;
                if (hdr_ready && !rst) begin
                    w_state_nxt = (r_hdr.n_payloads == 32'd0) ? HDR : PAYLOAD;
                end
            end
            PAYLOAD: begin
                m_valid = s_valid & !rst;
                s_ready = m_ready & !rst;
                m_last  = w_pc_last & !rst;
                if (m_valid && m_ready && w_pc_last) begin
                    w_state_nxt = HDR;
                end
            end
            DISCARD: begin
                s_ready = !rst;
                if (s_valid && !rst && (r_dc == 32'd1)) begin
                    w_state_nxt = HDR;
                end
            end
            default: w_state_nxt = HDR;
        endcase
    end

    // Header capture, discard/payload counters, error pulse and transaction count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hc  <= '0;
            r_hdr <= '0;
            r_pc  <= '0;
            r_dc  <= '0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_err <= 1'b0;
            if ((r_state == HDR) && w_s_acc) begin
                case (r_hc)
                    3'd0:    r_hdr.trnx_type[63:32] <= s_data;
                    3'd1:    r_hdr.trnx_type[31:0]  <= s_data;
                    3'd2:    r_hdr.trnx_id[63:32]   <= s_data;
                    3'd3:    r_hdr.trnx_id[31:0]    <= s_data;
                    3'd4:    r_hdr.data_type[63:32] <= s_data;
                    3'd5:    r_hdr.data_type[31:0]  <= s_data;
                    default: r_hdr.n_payloads       <= s_data;
                endcase
                r_hc <= w_hc_last ? '0 : r_hc + SVCS_HC_W'(1);
                if (w_hc_last && w_oversize) begin
                    r_err <= 1'b1;
                    r_dc  <= s_data;
                end
            end
            if ((r_state == DISCARD) && w_s_acc) begin
                r_dc <= r_dc - 32'd1;
            end
            if (w_hdr_acc) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_m_acc) begin
                r_pc <= w_pc_last ? '0 : r_pc + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_svcs_hs_rx_parser.sv
// Directed bench for svcs_hs_rx_parser: cycle table for a basic transaction,
// then hand-written sequences for the multi-cycle corner cases.
module tb_svcs_hs_rx_parser;

    localparam int unsigned IDX_W = 13;

    logic             clk = 1'b0;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic [31:0]      s_data;
    logic             hdr_valid;
    logic             hdr_ready;
    logic [63:0]      hdr_trnx_type;
    logic [63:0]      hdr_trnx_id;
    logic [63:0]      hdr_data_type;
    logic [31:0]      hdr_n_payloads;
    logic             m_valid;
    logic             m_ready;
    logic [31:0]      m_data;
    logic [IDX_W-1:0] m_index;
    logic             m_last;
    logic             err_oversize;
    logic [15:0]      trnx_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0]      d;
        logic [IDX_W-1:0] idx;
        logic             last;
    } beat_t;

    beat_t q[$];
    int    hdr_seen;
    int    err_seen;

    typedef struct {
        logic        sv;
        logic [31:0] sd;
        logic        exp_sr;
        logic        exp_hv;
        logic        exp_mv;
        logic [31:0] exp_md;
        logic [12:0] exp_mi;
        logic        exp_ml;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[12];

    svcs_hs_rx_parser #(.MAX_PAYLOADS(4096), .IDX_W(IDX_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .hdr_valid      (hdr_valid),
        .hdr_ready      (hdr_ready),
        .hdr_trnx_type  (hdr_trnx_type),
        .hdr_trnx_id    (hdr_trnx_id),
        .hdr_data_type  (hdr_data_type),
        .hdr_n_payloads (hdr_n_payloads),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_index        (m_index),
        .m_last         (m_last),
        .err_oversize   (err_oversize),
        .trnx_count     (trnx_count)
    );

    always #5 clk = ~clk;

    // Observe handshakes between the input drive (negedge) and the active edge.
    always @(negedge clk) begin
        #3;
        if (!rst) begin
            if (m_valid && m_ready) q.push_back('{d: m_data, idx: m_index, last: m_last});
            if (hdr_valid && hdr_ready) hdr_seen++;
            if (err_oversize) err_seen++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d);
        bit done = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int t = 0; t < 64 && !done; t++) begin
            #1;
            if (s_ready) done = 1'b1;
            @(negedge clk);
        end
        s_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL push_timeout: word 0x%0h not accepted within 64 cycles", d);
        end
    endtask

    task automatic push_hdr(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                            input logic [31:0] w3, input logic [31:0] w4, input logic [31:0] w5,
                            input logic [31:0] n);
        push(w0); push(w1); push(w2); push(w3); push(w4); push(w5); push(n);
    endtask

    task automatic expect_beat(input string name, input int k, input logic [31:0] d,
                               input int idx, input logic last);
        if (k >= q.size()) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: beat %0d missing, got %0d beats", name, k, q.size());
        end else begin
            check({name, "_data"}, 64'(q[k].d), 64'(d));
            check({name, "_idx"}, 64'(q[k].idx), 64'(idx));
            check({name, "_last"}, 64'(q[k].last), 64'(last));
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        hdr_ready = 1'b1;
        m_ready   = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete();
        hdr_seen = 0;
        err_seen = 0;
    endtask

    initial begin
        rst       = 1'b1;
        s_valid   = 1'b1;
        s_data    = 32'hDEAD_BEEF;
        hdr_ready = 1'b1;
        m_ready   = 1'b1;
        hdr_seen  = 0;
        err_seen  = 0;

        vecs[0]  = '{1'b1, 32'h1, 1'b1, 1'b0, 1'b0, 32'h0, 13'd0, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 32'h2, 1'b1, 1'b0, 1'b0, 32'h0, 13'd0, 1'b0, 16'd0};
        vecs[2]  = '{1'b1, 32'h3, 1'b1, 1'b0, 1'b0, 32'h0, 13'd0, 1'b0, 16'd0};
        vecs[3]  = '{1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 13'd0, 1'b0, 16'd0};
        vecs[4]  = '{1'b1, 32'h5, 1'b1, 1'b0, 1'b0, 32'h0, 13'd0, 1'b0, 16'd0};
        vecs[5]  = '{1'b1, 32'h6, 1'b1, 1'b0, 1'b0, 32'h0, 13'd0, 1'b0, 16'd0};
        vecs[6]  = '{1'b1, 32'h3, 1'b1, 1'b0, 1'b0, 32'h0, 13'd0, 1'b0, 16'd0};
        vecs[7]  = '{1'b1, 32'hA, 1'b0, 1'b1, 1'b0, 32'h0, 13'd0, 1'b0, 16'd0};
        vecs[8]  = '{1'b1, 32'hA, 1'b1, 1'b0, 1'b1, 32'hA, 13'd0, 1'b0, 16'd1};
        vecs[9]  = '{1'b1, 32'hB, 1'b1, 1'b0, 1'b1, 32'hB, 13'd1, 1'b0, 16'd1};
        vecs[10] = '{1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 32'hC, 13'd2, 1'b1, 16'd1};
        vecs[11] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 13'd0, 1'b0, 16'd1};

        // Reset values with s_valid asserted.
        repeat (2) @(negedge clk);
        #3;
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_hdr_valid", 64'(hdr_valid), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_err", 64'(err_oversize), 64'd0);
        check("rst_cnt", 64'(trnx_count), 64'd0);
        check("rst_trnx_type", hdr_trnx_type, 64'd0);
        check("rst_n_payloads", 64'(hdr_n_payloads), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic n=3 transaction, cycle by cycle.
        for (int i = 0; i < 12; i++) begin
            s_valid = vecs[i].sv;
            s_data  = vecs[i].sd;
            #3;
            check($sformatf("t1_s_ready[%0d]", i), 64'(s_ready), 64'(vecs[i].exp_sr));
            check($sformatf("t1_hdr_valid[%0d]", i), 64'(hdr_valid), 64'(vecs[i].exp_hv));
            check($sformatf("t1_m_valid[%0d]", i), 64'(m_valid), 64'(vecs[i].exp_mv));
            check($sformatf("t1_m_last[%0d]", i), 64'(m_last), 64'(vecs[i].exp_ml));
            check($sformatf("t1_cnt[%0d]", i), 64'(trnx_count), 64'(vecs[i].exp_cnt));
            check($sformatf("t1_err[%0d]", i), 64'(err_oversize), 64'd0);
            if (vecs[i].exp_mv) begin
                check($sformatf("t1_m_data[%0d]", i), 64'(m_data), 64'(vecs[i].exp_md));
                check($sformatf("t1_m_index[%0d]", i), 64'(m_index), 64'(vecs[i].exp_mi));
            end
            if (vecs[i].exp_hv) begin
                check("t1_hdr_n", 64'(hdr_n_payloads), 64'd3);
            end
            @(negedge clk);
        end
        check("t1_trnx_type", hdr_trnx_type, 64'h0000_0001_0000_0002);
        check("t1_trnx_id", hdr_trnx_id, 64'h0000_0003_0000_0004);
        check("t1_data_type", hdr_data_type, 64'h0000_0005_0000_0006);
        check("t1_hdr_seen", 64'(hdr_seen), 64'd1);
        check("t1_beats", 64'(q.size()), 64'd3);

        // n=0 immediately followed by n=1.
        do_reset();
        push_hdr(32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'd0);
        push_hdr(32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'h26, 32'd1);
        push(32'h77);
        check("t2_hdr_seen", 64'(hdr_seen), 64'd2);
        check("t2_beats", 64'(q.size()), 64'd1);
        expect_beat("t2_beat", 0, 32'h77, 0, 1'b1);
        check("t2_cnt", 64'(trnx_count), 64'd2);
        check("t2_trnx_type", hdr_trnx_type, 64'h0000_0021_0000_0022);

        // Oversize n=4097, discarded, then a legal n=1.
        do_reset();
        push_hdr(32'h31, 32'h32, 32'h33, 32'h34, 32'h35, 32'h36, 32'd4097);
        check("t3_err_pulse", 64'(err_oversize), 64'd1);
        check("t3_no_hdr", 64'(hdr_valid), 64'd0);
        for (int i = 0; i < 4097; i++) push(32'(i) ^ 32'h5A5A_0000);
        check("t3_err_seen", 64'(err_seen), 64'd1);
        check("t3_no_hdr_seen", 64'(hdr_seen), 64'd0);
        check("t3_no_beats", 64'(q.size()), 64'd0);
        push_hdr(32'h41, 32'h42, 32'h43, 32'h44, 32'h45, 32'h46, 32'd1);
        push(32'hBEEF);
        check("t3_hdr_seen", 64'(hdr_seen), 64'd1);
        check("t3_n", 64'(hdr_n_payloads), 64'd1);
        expect_beat("t3_beat", 0, 32'hBEEF, 0, 1'b1);
        check("t3_err_total", 64'(err_seen), 64'd1);
        check("t3_cnt", 64'(trnx_count), 64'd1);

        // Header back-pressure for 5 cycles.
        do_reset();
        hdr_ready = 1'b0;
        push_hdr(32'h51, 32'h52, 32'h53, 32'h54, 32'h55, 32'h56, 32'd2);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h55;
            #3;
            check($sformatf("t4_hdr_valid[%0d]", i), 64'(hdr_valid), 64'd1);
            check($sformatf("t4_s_ready[%0d]", i), 64'(s_ready), 64'd0);
            check($sformatf("t4_m_valid[%0d]", i), 64'(m_valid), 64'd0);
            check($sformatf("t4_id[%0d]", i), hdr_trnx_id, 64'h0000_0053_0000_0054);
            check($sformatf("t4_n[%0d]", i), 64'(hdr_n_payloads), 64'd2);
            @(negedge clk);
        end
        hdr_ready = 1'b1;
        push(32'h55);
        push(32'h66);
        check("t4_hdr_seen", 64'(hdr_seen), 64'd1);
        check("t4_beats", 64'(q.size()), 64'd2);
        expect_beat("t4_b0", 0, 32'h55, 0, 1'b0);
        expect_beat("t4_b1", 1, 32'h66, 1, 1'b1);

        // n=8 burst with m_ready toggling and random s_valid.
        do_reset();
        push_hdr(32'h61, 32'h62, 32'h63, 32'h64, 32'h65, 32'h66, 32'd8);
        begin
            int k = 0;
            for (int cyc = 0; cyc < 400 && k < 8; cyc++) begin
                m_ready = (cyc % 2 == 0);
                s_valid = 1'($urandom_range(0, 1));
                s_data  = 32'h100 + 32'(k);
                #1;
                if (s_valid && s_ready) k++;
                @(negedge clk);
            end
            s_valid = 1'b0;
            m_ready = 1'b1;
            check("t5_words_sent", 64'(k), 64'd8);
        end
        check("t5_beats", 64'(q.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            expect_beat($sformatf("t5_b%0d", k), k, 32'h100 + 32'(k), k, (k == 7));
        end
        check("t5_cnt", 64'(trnx_count), 64'd1);

        // Reset after header word 3, then a fresh transaction.
        push(32'h71); push(32'h72); push(32'h73); push(32'h74);
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'h75;
        @(negedge clk);
        #3;
        check("t6_s_ready", 64'(s_ready), 64'd0);
        check("t6_hdr_valid", 64'(hdr_valid), 64'd0);
        check("t6_m_valid", 64'(m_valid), 64'd0);
        check("t6_err", 64'(err_oversize), 64'd0);
        check("t6_cnt", 64'(trnx_count), 64'd0);
        check("t6_trnx_type", hdr_trnx_type, 64'd0);
        check("t6_trnx_id", hdr_trnx_id, 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        s_valid = 1'b0;
        q.delete();
        hdr_seen = 0;
        err_seen = 0;
        push_hdr(32'h81, 32'h82, 32'h83, 32'h84, 32'h85, 32'h86, 32'd1);
        push(32'h99);
        check("t6_hdr_seen", 64'(hdr_seen), 64'd1);
        check("t6_trnx_type_new", hdr_trnx_type, 64'h0000_0081_0000_0082);
        expect_beat("t6_beat", 0, 32'h99, 0, 1'b1);
        check("t6_cnt_after", 64'(trnx_count), 64'd1);
        check("t6_err_seen", 64'(err_seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
